// File: rtl/bram_rd_ctrl_if.sv
// bram_rd_ctrl_if: request, BRAM and response signals of the BRAM read controller
//   master: client/BRAM side (drives req_valid, req_addr, rsp_ready, mem_rdata)
//   slave : controller side (drives req_ready, mem_rd, mem_addr, rsp_valid, rsp_data)
interface bram_rd_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   modport master (
      output req_valid, req_addr, rsp_ready, mem_rdata,
      input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data
   );
   modport slave (
      input  req_valid, req_addr, rsp_ready, mem_rdata,
      output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data
   );
endinterface

// File: rtl/bram_rd_ctrl.sv
// bram_rd_ctrl: fixed-latency BRAM read controller with valid/ready request and response
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : request/BRAM/response channel (slave side)
//   busy         : high while a read is in flight or its response is pending
//   rd_count     : completed reads, saturating
module bram_rd_ctrl #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int RD_LATENCY = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   bram_rd_ctrl_if.slave    bus,
   output logic             busy,
   output logic [CNT_W-1:0] rd_count
);
   localparam int LW = $clog2(RD_LATENCY + 1);
   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
   state_t            state;
   logic [LW-1:0]     cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   assign bus.mem_addr = addr_q;
   assign bus.rsp_data = data_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         bus.req_ready <= 1'b0;
         bus.mem_rd    <= 1'b0;
         bus.rsp_valid <= 1'b0;
         busy          <= 1'b0;
         rd_count      <= '0;
      end else
         case (state)
            IDLE:
               if (bus.req_valid && bus.req_ready) begin
                  addr_q        <= bus.req_addr;
                  bus.mem_rd    <= 1'b1;
                  bus.req_ready <= 1'b0;
                  busy          <= 1'b1;
                  cnt           <= LW'(RD_LATENCY - 1);
                  state         <= READ;
               end else
                  bus.req_ready <= 1'b1;
            READ:
               if (cnt == '0) begin
                  data_q        <= bus.mem_rdata;
                  bus.mem_rd    <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else
                  cnt <= cnt - 1'b1;
            RESP:
               if (bus.rsp_ready) begin
                  // req_ready rises with the return to IDLE, so the next accept is one edge later
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  busy          <= 1'b0;
                  rd_count      <= rd_count + CNT_W'(~&rd_count);
                  state         <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_bram_rd_ctrl.sv
// tb_bram_rd_ctrl: directed checks of bram_rd_ctrl across several latencies and counter widths
module tb_bram_rd_ctrl;
   logic       clk = 0;
   logic       rst = 0;
   logic       rv = 0;
   logic       rr = 0;
   logic [9:0] ra = '0;
   logic [2:0] sel = '0;
   int         checks = 0;
   int         errors = 0;
   logic        rq_o  [5];
   logic        mrd_o [5];
   logic        rsv_o [5];
   logic        bsy_o [5];
   logic [9:0]  ma_o  [5];
   logic [31:0] rsd_o [5];
   logic [15:0] cnt_o [5];
   logic        rq, mrd, rsv, bsy;
   logic [9:0]  ma;
   logic [31:0] rsd;
   logic [15:0] cnt;
   assign rq  = rq_o[sel];
   assign mrd = mrd_o[sel];
   assign rsv = rsv_o[sel];
   assign bsy = bsy_o[sel];
   assign ma  = ma_o[sel];
   assign rsd = rsd_o[sel];
   assign cnt = cnt_o[sel];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 5; g++) begin : gi
      localparam int L  = g == 1 ? 1 : g == 2 ? 4 : g == 3 ? 16 : 2;
      localparam int CW = g == 4 ? 3 : 16;
      bram_rd_ctrl_if #(.DATA_W(32), .ADDR_W(10)) b ();
      logic [CW-1:0] rc;
      logic          bz;
      logic [4:0]    n;
      assign b.req_valid = rv && sel == g;
      assign b.req_addr  = ra;
      assign b.rsp_ready = rr && sel == g;
      // BRAM model: data is valid only at the edge that samples mem_rd high for the L-th time
      always @(posedge clk or posedge rst)
         if (rst) n <= '0;
         else n <= b.mem_rd ? n + 5'd1 : 5'd0;
      assign b.mem_rdata = (b.mem_rd && n == 5'(L - 1)) ? (32'hA5A5_0000 | {22'b0, b.mem_addr}) : 32'hDEAD_BEEF;
      bram_rd_ctrl #(.DATA_W(32), .ADDR_W(10), .RD_LATENCY(L), .CNT_W(CW)) u (
         .clk(clk), .rst(rst), .bus(b.slave), .busy(bz), .rd_count(rc)
      );
      assign rq_o[g]  = b.req_ready;
      assign mrd_o[g] = b.mem_rd;
      assign rsv_o[g] = b.rsp_valid;
      assign ma_o[g]  = b.mem_addr;
      assign rsd_o[g] = b.rsp_data;
      assign bsy_o[g] = bz;
      assign cnt_o[g] = 16'(rc);
   end
   // w: edges that sample mem_rd high; t: cycles from accept to rsp_valid
   task automatic issue(input logic [9:0] a, output int w, output int t, output bit ok);
      ok = 1; w = 0; t = 0;
      for (int i = 0; i < 50 && !rq; i++) @(negedge clk);
      if (!rq) begin ok = 0; return; end
      rv = 1; ra = a;
      @(negedge clk);
      rv = 0; ra = ~a;
      for (int i = 0; i < 40 && !rsv; i++) begin
         if (mrd) w++;
         if (mrd && ma !== a) ok = 0;
         @(negedge clk);
         t++;
      end
      if (!rsv || mrd) ok = 0;
   endtask
   task automatic test_reset;
      #1 rst = 1;
      repeat (4) begin
         @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            checks++;
            if ({rq_o[k], mrd_o[k], rsv_o[k], bsy_o[k], ma_o[k], rsd_o[k], cnt_o[k]} !== '0) begin
               errors++;
               $display("FAIL reset_outputs[%0d]: got rq=%b mrd=%b rsv=%b busy=%b addr=%h data=%h cnt=%0d want all 0",
                        k, rq_o[k], mrd_o[k], rsv_o[k], bsy_o[k], ma_o[k], rsd_o[k], cnt_o[k]);
            end
         end
      end
      rst = 0;
      #1 checks++;
      if (rq !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b want 0", rq); end
      @(negedge clk);
      checks++;
      if (rq !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b want 1", rq); end
   endtask
   task automatic test_single;
      int w, t; bit ok;
      sel = 0; rr = 1;
      issue(10'h005, w, t, ok);
      checks++;
      if (!ok || w !== 2) begin errors++; $display("FAIL single_width: got %0d ok=%0b want 2", w, ok); end
      checks++;
      if (t !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", t); end
      checks++;
      if (rsd !== 32'hA5A5_0005) begin errors++; $display("FAIL single_data: got %h want a5a50005", rsd); end
      checks++;
      if (bsy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bsy); end
      @(negedge clk);
      checks++;
      if ({rsv, rq, bsy} !== 3'b010) begin errors++; $display("FAIL single_done: got rsv/rq/busy=%b want 010", {rsv, rq, bsy}); end
      checks++;
      if (cnt !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", cnt); end
   endtask
   task automatic test_backpressure;
      int w, t; bit ok;
      sel = 0; rr = 0;
      issue(10'h3C2, w, t, ok);
      checks++;
      if (!ok || w !== 2) begin errors++; $display("FAIL bp_width: got %0d ok=%0b want 2", w, ok); end
      for (int i = 0; i < 5; i++) begin
         rv = 1; ra = 10'h111;
         @(negedge clk);
         checks++;
         if ({rsv, rq, mrd, rsd} !== {3'b100, 32'hA5A5_03C2}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got rsv=%b rq=%b mrd=%b data=%h want 1 0 0 a5a503c2", i, rsv, rq, mrd, rsd);
         end
      end
      rv = 0; rr = 1;
      @(negedge clk);
      checks++;
      if ({rsv, rq} !== 2'b01 || cnt !== 16'd2) begin
         errors++;
         $display("FAIL bp_release: got rsv=%b rq=%b cnt=%0d want 0 1 2", rsv, rq, cnt);
      end
      @(negedge clk);
      checks++;
      if ({mrd, bsy} !== 2'b00) begin errors++; $display("FAIL bp_ignored: got mrd=%b busy=%b want 0 0", mrd, bsy); end
   endtask
   task automatic test_latency_sweep;
      int w, t; bit ok;
      logic [9:0] a;
      rr = 1;
      for (int s = 1; s <= 3; s++) begin
         int lat;
         sel = 3'(s);
         lat = s == 1 ? 1 : s == 2 ? 4 : 16;
         for (int i = 0; i < 10; i++) begin
            a = 10'($urandom_range(0, 1023));
            issue(a, w, t, ok);
            checks++;
            if (!ok || w !== lat) begin errors++; $display("FAIL sweep_width L%0d #%0d: got %0d ok=%0b want %0d", lat, i, w, ok, lat); end
            checks++;
            if (rsd !== (32'hA5A5_0000 | {22'b0, a})) begin
               errors++;
               $display("FAIL sweep_data L%0d #%0d: got %h want %h", lat, i, rsd, 32'hA5A5_0000 | {22'b0, a});
            end
         end
         @(negedge clk);
         checks++;
         if (cnt !== 16'd10) begin errors++; $display("FAIL sweep_count L%0d: got %0d want 10", lat, cnt); end
      end
   endtask
   task automatic test_reset_mid_read;
      int w, t; bit ok;
      sel = 2; rr = 1;
      rv = 1; ra = 10'h2AA;
      @(negedge clk);
      rv = 0;
      @(negedge clk);
      checks++;
      if (mrd !== 1'b1) begin errors++; $display("FAIL mid_in_read: got mrd=%b want 1", mrd); end
      #2 rst = 1;
      #1 checks++;
      if ({mrd, rsv, bsy} !== 3'b000 || cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_abort: got mrd=%b rsv=%b busy=%b cnt=%0d want 0 0 0 0", mrd, rsv, bsy, cnt);
      end
      @(negedge clk);
      rst = 0;
      issue(10'h155, w, t, ok);
      checks++;
      if (!ok || w !== 4) begin errors++; $display("FAIL mid_after_width: got %0d ok=%0b want 4", w, ok); end
      checks++;
      if (rsd !== 32'hA5A5_0155) begin errors++; $display("FAIL mid_after_data: got %h want a5a50155", rsd); end
      @(negedge clk);
      checks++;
      if (cnt !== 16'd1) begin errors++; $display("FAIL mid_after_count: got %0d want 1", cnt); end
   endtask
   task automatic test_saturation;
      int w, t; bit ok;
      sel = 4; rr = 1;
      for (int i = 0; i < 9; i++) begin
         issue(10'(i * 37), w, t, ok);
         checks++;
         if (!ok || w !== 2) begin errors++; $display("FAIL sat_width #%0d: got %0d ok=%0b want 2", i, w, ok); end
         @(negedge clk);
         checks++;
         if (cnt !== 16'(i + 1 > 7 ? 7 : i + 1)) begin
            errors++;
            $display("FAIL sat_count #%0d: got %0d want %0d", i, cnt, i + 1 > 7 ? 7 : i + 1);
         end
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end
   initial begin
      test_reset;
      test_single;
      test_backpressure;
      test_latency_sweep;
      test_reset_mid_read;
      test_saturation;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
